// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO, registered ALU drive and result capture around a combinational ALU.
// Optional ALU_ISSUE_STICKY_FLAGS_EN adds sticky carry/overflow flags with a clear input.
module alu_issue_stage #(
    parameter int DWIDTH = 128,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DWIDTH-1:0]          in_op1,
    input  logic [DWIDTH-1:0]          in_op2,
    input  logic [2:0]                 in_opsel,
    input  logic                       in_mode,
    output logic [DWIDTH-1:0]          alu_op1,
    output logic [DWIDTH-1:0]          alu_op2,
    output logic [2:0]                 alu_opsel,
    output logic                       alu_mode,
    input  logic [DWIDTH-1:0]          alu_result,
    input  logic                       alu_c,
    input  logic                       alu_z,
    input  logic                       alu_o,
    input  logic                       alu_s,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DWIDTH-1:0]          out_result,
    output logic                       out_c,
    output logic                       out_z,
    output logic                       out_o,
    output logic                       out_s,
    output logic                       err,
`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    input  logic                       sticky_clr,
    output logic                       sticky_c,
    output logic                       sticky_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 2 * DWIDTH + 4;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] left, count_nxt;
    logic [EW-1:0] in_entry, head_nxt;
    logic          illegal, push, pop;

    assign in_ready  = !rst && (count < CW'(DEPTH));
    // The ALU leaves its carry-in undriven for these combinations, so they are dropped here.
    assign illegal   = (in_opsel == 3'b111) || (in_mode && (in_opsel == 3'b100 || in_opsel == 3'b110));
    assign push      = in_valid && in_ready && !illegal;
    assign pop       = (count != '0) && (!out_valid || out_ready);
    assign in_entry  = {in_op1, in_op2, in_opsel, in_mode};
    assign rd_nxt    = rd_ptr + PW'(pop);
    assign left      = count - CW'(pop);
    assign count_nxt = left + CW'(push);
    // If nothing survives the pop, the new head can only be the entry being pushed.
    assign head_nxt  = (left == '0) ? in_entry : mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err        <= 1'b0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_opsel  <= 3'b000;
            alu_mode   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            {out_c, out_z, out_o, out_s} <= 4'b0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(push);
            rd_ptr    <= rd_nxt;
            count     <= count_nxt;
            err       <= in_valid && in_ready && illegal;
            out_valid <= pop || (out_valid && !out_ready);
            if (count_nxt != '0) {alu_op1, alu_op2, alu_opsel, alu_mode} <= head_nxt;
            if (pop) begin
                out_result <= alu_result;
                {out_c, out_z, out_o, out_s} <= {alu_c, alu_z, alu_o, alu_s};
            end
        end
    end

`ifdef ALU_ISSUE_STICKY_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_c <= 1'b0;
            sticky_o <= 1'b0;
        end else begin
            sticky_c <= (sticky_c && !sticky_clr) || (pop && alu_c);
            sticky_o <= (sticky_o && !sticky_clr) || (pop && alu_o);
        end
    end
`endif
endmodule
